// File: rtl/mem_str_fwd_ctrl.sv
// Store-data forwarding select and data-memory write handshake for the MEM stage.
// Latches per-field forwarding selects on store acceptance and holds them while waiting for mem_ack.
//
// state | meaning
// IDLE  | no store outstanding; selects driven to zero
// REQ   | store write requested; pipeline frozen, selects held, wait counter running

module mem_str_fwd_ctrl #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ex_mem_valid,
   input  logic       ex_mem_store,
   input  logic [3:0] ex_mem_src_top,
   input  logic [3:0] ex_mem_src_bot,
   input  logic       mem_wb_valid,
   input  logic       mem_wb_we_top,
   input  logic [3:0] mem_wb_dst_top,
   input  logic       mem_wb_we_bot,
   input  logic [3:0] mem_wb_dst_bot,
   input  logic       mem_ack,
   output logic [2:0] sel_signal_top,
   output logic [2:0] sel_signal_bot,
   output logic       mem_wr_req,
   output logic       pipe_stall,
   output logic       err_timeout
);

   typedef enum logic {IDLE, REQ} state_t;

   localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [2:0] sel_top_q, sel_top_d;
   logic [2:0] sel_bot_q, sel_bot_d;
   logic       req_q, req_d;
   logic       err_q, err_d;

   logic       hit_top_t, hit_top_b, hit_bot_t, hit_bot_b;
   logic [2:0] fwd_top, fwd_bot;

   assign hit_top_t = mem_wb_valid & mem_wb_we_top & (mem_wb_dst_top == ex_mem_src_top);
   assign hit_top_b = mem_wb_valid & mem_wb_we_bot & (mem_wb_dst_bot == ex_mem_src_top);
   assign hit_bot_t = mem_wb_valid & mem_wb_we_top & (mem_wb_dst_top == ex_mem_src_bot);
   assign hit_bot_b = mem_wb_valid & mem_wb_we_bot & (mem_wb_dst_bot == ex_mem_src_bot);

   // MEM/WB top result wins when both halves of MEM/WB target the same source
   assign fwd_top = hit_top_t ? 3'b010 : (hit_top_b ? 3'b100 : 3'b001);
   assign fwd_bot = hit_bot_t ? 3'b010 : (hit_bot_b ? 3'b100 : 3'b001);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sel_top_d = sel_top_q;
      sel_bot_d = sel_bot_q;
      req_d     = req_q;
      err_d     = err_q;
      case (state_q)
         IDLE: begin
            if (ex_mem_valid && ex_mem_store) begin
               state_d   = REQ;
               cnt_d     = 4'd0;
               sel_top_d = fwd_top;
               sel_bot_d = fwd_bot;
               req_d     = 1'b1;
            end else begin
               sel_top_d = 3'b000;
               sel_bot_d = 3'b000;
               req_d     = 1'b0;
            end
         end
         REQ: begin
            if (mem_ack || (cnt_q == CNT_LAST)) begin
               state_d   = IDLE;
               sel_top_d = 3'b000;
               sel_bot_d = 3'b000;
               req_d     = 1'b0;
               // an ack arriving on the final allowed cycle still counts as success
               if (!mem_ack) err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= 4'd0;
         sel_top_q <= 3'b000;
         sel_bot_q <= 3'b000;
         req_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sel_top_q <= sel_top_d;
         sel_bot_q <= sel_bot_d;
         req_q     <= req_d;
         err_q     <= err_d;
      end
   end

   assign sel_signal_top = sel_top_q;
   assign sel_signal_bot = sel_bot_q;
   assign mem_wr_req     = req_q;
   assign pipe_stall     = req_q;
   assign err_timeout    = err_q;

endmodule

// File: tb/tb_mem_str_fwd_ctrl.sv
// Bench for mem_str_fwd_ctrl: directed scenarios plus random traffic,
// checked every cycle against a transaction-level model of the store handshake.

module tb_mem_str_fwd_ctrl;

   localparam int TIMEOUT = 15;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       ex_mem_valid = 1'b0, ex_mem_store = 1'b0;
   logic [3:0] ex_mem_src_top = 4'd0, ex_mem_src_bot = 4'd0;
   logic       mem_wb_valid = 1'b0, mem_wb_we_top = 1'b0, mem_wb_we_bot = 1'b0;
   logic [3:0] mem_wb_dst_top = 4'd0, mem_wb_dst_bot = 4'd0;
   logic       mem_ack = 1'b0;
   logic [2:0] sel_signal_top, sel_signal_bot;
   logic       mem_wr_req, pipe_stall, err_timeout;

   int checks = 0;
   int errors = 0;

   mem_str_fwd_ctrl #(.TIMEOUT(TIMEOUT)) dut (
      .clock          (clock),
      .reset          (reset),
      .ex_mem_valid   (ex_mem_valid),
      .ex_mem_store   (ex_mem_store),
      .ex_mem_src_top (ex_mem_src_top),
      .ex_mem_src_bot (ex_mem_src_bot),
      .mem_wb_valid   (mem_wb_valid),
      .mem_wb_we_top  (mem_wb_we_top),
      .mem_wb_dst_top (mem_wb_dst_top),
      .mem_wb_we_bot  (mem_wb_we_bot),
      .mem_wb_dst_bot (mem_wb_dst_bot),
      .mem_ack        (mem_ack),
      .sel_signal_top (sel_signal_top),
      .sel_signal_bot (sel_signal_bot),
      .mem_wr_req     (mem_wr_req),
      .pipe_stall     (pipe_stall),
      .err_timeout    (err_timeout)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: one outstanding store with the number of request cycles it has waited
   bit         m_busy = 1'b0;
   int         m_waited = 0;
   logic       m_req = 1'b0;
   logic [2:0] m_sel_top = 3'b000, m_sel_bot = 3'b000;
   logic       m_err = 1'b0;
   bit         cmp_en = 1'b0;

   function automatic logic [2:0] exp_sel(input logic [3:0] src);
      if (mem_wb_valid && mem_wb_we_top && mem_wb_dst_top == src) return 3'b010;
      if (mem_wb_valid && mem_wb_we_bot && mem_wb_dst_bot == src) return 3'b100;
      return 3'b001;
   endfunction

   always @(posedge clock) begin
      if (reset) begin
         m_busy = 1'b0; m_waited = 0; m_req = 1'b0;
         m_sel_top = 3'b000; m_sel_bot = 3'b000; m_err = 1'b0;
      end else if (m_busy) begin
         m_waited++;
         if (mem_ack || m_waited == TIMEOUT) begin
            if (!mem_ack) m_err = 1'b1;
            m_busy = 1'b0; m_req = 1'b0;
            m_sel_top = 3'b000; m_sel_bot = 3'b000;
         end
      end else if (ex_mem_valid && ex_mem_store) begin
         m_busy = 1'b1; m_waited = 0; m_req = 1'b1;
         m_sel_top = exp_sel(ex_mem_src_top);
         m_sel_bot = exp_sel(ex_mem_src_bot);
      end else begin
         m_req = 1'b0; m_sel_top = 3'b000; m_sel_bot = 3'b000;
      end
   end

   always @(negedge clock) begin
      if (cmp_en) begin
         check("m_req",     32'(mem_wr_req),     32'(m_req));
         check("m_stall",   32'(pipe_stall),     32'(m_req));
         check("m_sel_top", 32'(sel_signal_top), 32'(m_sel_top));
         check("m_sel_bot", 32'(sel_signal_bot), 32'(m_sel_bot));
         check("m_err",     32'(err_timeout),    32'(m_err));
         check("onehot",    32'($countones(sel_signal_top) <= 1 && $countones(sel_signal_bot) <= 1), 32'd1);
      end
   end

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic set_store(input logic [3:0] top, input logic [3:0] bot);
      ex_mem_valid = 1'b1; ex_mem_store = 1'b1;
      ex_mem_src_top = top; ex_mem_src_bot = bot;
   endtask

   task automatic clr_store();
      ex_mem_valid = 1'b0; ex_mem_store = 1'b0;
   endtask

   task automatic clr_wb();
      mem_wb_valid = 1'b0; mem_wb_we_top = 1'b0; mem_wb_we_bot = 1'b0;
      mem_wb_dst_top = 4'd0; mem_wb_dst_bot = 4'd0;
   endtask

   task automatic ack_once();
      mem_ack = 1'b1; tick(); mem_ack = 1'b0;
   endtask

   initial begin
      int n;
      int mode;
      tick();
      cmp_en = 1'b1;
      tick();
      check("rst_req", 32'(mem_wr_req), 32'd0);
      check("rst_err", 32'(err_timeout), 32'd0);
      check("rst_sel", 32'({sel_signal_top, sel_signal_bot}), 32'd0);
      reset = 1'b0;

      // plain store, no forwarding, ack on second request cycle
      set_store(4'd5, 4'd3); tick(); clr_store();
      check("s1_req0", 32'(mem_wr_req), 32'd1);
      check("s1_stall0", 32'(pipe_stall), 32'd1);
      check("s1_sel_top", 32'(sel_signal_top), 32'b001);
      check("s1_sel_bot", 32'(sel_signal_bot), 32'b001);
      tick();
      check("s1_req1", 32'(mem_wr_req), 32'd1);
      ack_once();
      check("s1_req2", 32'(mem_wr_req), 32'd0);
      check("s1_sel_off", 32'({sel_signal_top, sel_signal_bot}), 32'd0);

      // forwarding priority and input freeze during REQ
      mem_wb_valid = 1'b1; mem_wb_we_top = 1'b1; mem_wb_dst_top = 4'd4;
      mem_wb_we_bot = 1'b1; mem_wb_dst_bot = 4'd4;
      set_store(4'd0, 4'd4); tick(); clr_store();
      check("f1_sel_bot", 32'(sel_signal_bot), 32'b010);
      check("f1_sel_top", 32'(sel_signal_top), 32'b001);
      mem_wb_dst_top = 4'd0; tick();
      check("f1_hold_top", 32'(sel_signal_top), 32'b001);
      ack_once();
      mem_wb_we_top = 1'b0; mem_wb_we_bot = 1'b1; mem_wb_dst_bot = 4'd7;
      set_store(4'd7, 4'd1); tick(); clr_store(); clr_wb();
      check("f2_sel_top", 32'(sel_signal_top), 32'b100);
      check("f2_sel_bot", 32'(sel_signal_bot), 32'b001);
      ack_once();

      // back-to-back stores: request pattern 1,0,1
      set_store(4'd0, 4'd2); tick();
      check("b2b_req_a", 32'(mem_wr_req), 32'd1);
      set_store(4'd0, 4'd9);
      mem_wb_valid = 1'b1; mem_wb_we_bot = 1'b1; mem_wb_dst_bot = 4'd9;
      ack_once();
      check("b2b_req_b", 32'(mem_wr_req), 32'd0);
      tick(); clr_store(); clr_wb();
      check("b2b_req_c", 32'(mem_wr_req), 32'd1);
      check("b2b_sel_bot", 32'(sel_signal_bot), 32'b100);
      ack_once();

      // timeout: request held TIMEOUT cycles, sticky error, later store still serviced
      set_store(4'd1, 4'd1); tick(); clr_store();
      n = 1;
      for (int i = 0; i < 40 && mem_wr_req; i++) begin
         tick();
         if (mem_wr_req) n++;
      end
      check("to_len", 32'(n), 32'd15);
      check("to_err", 32'(err_timeout), 32'd1);
      set_store(4'd2, 4'd2); tick(); clr_store();
      check("to_next_req", 32'(mem_wr_req), 32'd1);
      ack_once();
      check("to_next_done", 32'(mem_wr_req), 32'd0);
      check("to_err_sticky", 32'(err_timeout), 32'd1);

      // ack on the last allowed cycle is a success
      reset = 1'b1; tick(); reset = 1'b0;
      check("rst_clr_err", 32'(err_timeout), 32'd0);
      set_store(4'd3, 4'd3); tick(); clr_store();
      repeat (14) tick();
      check("edge_req", 32'(mem_wr_req), 32'd1);
      ack_once();
      check("edge_done", 32'(mem_wr_req), 32'd0);
      check("edge_err", 32'(err_timeout), 32'd0);

      // reset in third request cycle wins over ack and a pending store
      set_store(4'd6, 4'd6); tick(); clr_store();
      tick(); tick();
      reset = 1'b1; mem_ack = 1'b1; set_store(4'd6, 4'd6);
      tick();
      reset = 1'b0; clr_store();
      check("rst_req_mid", 32'(mem_wr_req), 32'd0);
      check("rst_stall_mid", 32'(pipe_stall), 32'd0);
      check("rst_sel_mid", 32'({sel_signal_top, sel_signal_bot}), 32'd0);
      tick(); mem_ack = 1'b0;
      check("idle_ack_req", 32'(mem_wr_req), 32'd0);
      check("idle_ack_err", 32'(err_timeout), 32'd0);

      // random traffic; ack density changes per block to reach timeouts too
      mode = 0;
      for (int c = 0; c < 1200; c++) begin
         if (c % 64 == 0) mode = int'($urandom_range(0, 2));
         reset          = ($urandom_range(0, 99) == 0);
         ex_mem_valid   = 1'($urandom);
         ex_mem_store   = 1'($urandom);
         ex_mem_src_top = 4'($urandom_range(0, 3));
         ex_mem_src_bot = 4'($urandom_range(0, 3));
         mem_wb_valid   = 1'($urandom);
         mem_wb_we_top  = 1'($urandom);
         mem_wb_we_bot  = 1'($urandom);
         mem_wb_dst_top = 4'($urandom_range(0, 3));
         mem_wb_dst_bot = 4'($urandom_range(0, 3));
         case (mode)
            0:       mem_ack = 1'($urandom);
            1:       mem_ack = ($urandom_range(0, 7) == 0);
            default: mem_ack = 1'b0;
         endcase
         tick();
      end
      reset = 1'b0; clr_store(); clr_wb(); mem_ack = 1'b0;
      tick(); tick();
      cmp_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_str_fwd_ctrl.md
MEM_STR_FWD_CTRL -- requirements
Module: mem_str_fwd_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 15, number of REQ cycles without mem_ack before abort (range 1..15).
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 ex_mem_valid  input  1  EX/MEM holds a valid instruction.
REQ-005 ex_mem_store  input  1  EX/MEM instruction is a store.
REQ-006 ex_mem_src_top  input  4  register index supplying store data bits [11:8].
REQ-007 ex_mem_src_bot  input  4  register index supplying store data bits [7:0].
REQ-008 mem_wb_valid  input  1  MEM/WB holds a valid instruction.
REQ-009 mem_wb_we_top  input  1  MEM/WB writes its top result byte.
REQ-010 mem_wb_dst_top  input  4  destination index of MEM/WB top result.
REQ-011 mem_wb_we_bot  input  1  MEM/WB writes its bottom result byte.
REQ-012 mem_wb_dst_bot  input  4  destination index of MEM/WB bottom result.
REQ-013 mem_ack  input  1  data memory accepted the write this cycle.
REQ-014 sel_signal_top  output  3  one-hot store-data select, bits [11:8]: [0] EX/MEM, [1] MEM/WB top, [2] MEM/WB bot.
REQ-015 sel_signal_bot  output  3  one-hot store-data select, bits [7:0], same encoding.
REQ-016 mem_wr_req  output  1  store write request to data memory.
REQ-017 pipe_stall  output  1  freezes EX/MEM and MEM/WB registers.
REQ-018 err_timeout  output  1  sticky flag: a store was aborted on timeout.

Function
REQ-019 All outputs SHALL be registered; the block SHALL have two states: IDLE, REQ.
REQ-020 Forward hit top-source: hitT = mem_wb_valid & mem_wb_we_top & (mem_wb_dst_top == src); hitB likewise with we_bot/dst_bot.
REQ-021 Select per field: hitT -> 3'b010; else hitB -> 3'b100; else 3'b001; hitT SHALL win when both hit.
REQ-022 IDLE, ex_mem_valid & ex_mem_store at edge N: latch both selects, go REQ; mem_wr_req=1 and pipe_stall=1 from N+1.
REQ-023 IDLE with no store: mem_wr_req=0, pipe_stall=0, both selects SHALL be 3'b000 (mux drives zero).
REQ-024 REQ: selects SHALL hold latched values; ex_mem_* and mem_wb_* inputs SHALL be ignored.
REQ-025 REQ with mem_ack at edge M: go IDLE; mem_wr_req, pipe_stall, selects SHALL be 0 from M+1.
REQ-026 Back-to-back stores: a store present in IDLE at M+1 SHALL be accepted at M+1 with no bubble (req again at M+2).
REQ-027 Wait counter (4-bit) SHALL clear on REQ entry, increment each REQ cycle without mem_ack.
REQ-028 Counter reaching TIMEOUT without mem_ack: go IDLE, drop req/stall/selects next cycle, set err_timeout.
REQ-029 mem_ack in the same cycle the counter reaches TIMEOUT SHALL count as success; err_timeout unchanged.
REQ-030 mem_ack while IDLE SHALL be ignored.
REQ-031 err_timeout SHALL stay 1 until reset; later stores SHALL still be serviced normally.
REQ-032 Selects SHALL always be one-hot or all-zero; never multi-hot.

Reset
REQ-033 reset high at an edge SHALL force IDLE, counter=0, all outputs 0, including err_timeout.
REQ-034 reset during REQ SHALL abandon the store: mem_wr_req and pipe_stall low the cycle after reset edge; no err_timeout.
REQ-035 reset SHALL take priority over mem_ack and store acceptance in the same cycle.

Verification
REQ-036 Store, src_bot=3, src_top=5, no MEM/WB writes, ack 2 cycles after req -> sel_bot=001, sel_top=001, req/stall high exactly 2 cycles.
REQ-037 Store src_bot=4, MEM/WB we_top=1 dst_top=4, we_bot=1 dst_bot=4 -> sel_bot=010 (top priority); src_top=7 with dst_bot=7 only -> sel_top=100.
REQ-038 Two consecutive stores, ack on first REQ cycle each -> req pattern 1,0,1; second store's selects from its own acceptance cycle.
REQ-039 Store, mem_ack never asserted, TIMEOUT=15 -> req high 15 cycles then low, err_timeout=1 and stays 1 across a following successful store.
REQ-040 Ack coinciding with counter==TIMEOUT -> err_timeout stays 0; reset asserted in 3rd REQ cycle -> all outputs 0 next cycle, later ack ignored.
